// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Accumulates a programmable number of unsigned WIDTH-bit samples from the
//   adder stage into an ACC_WIDTH-bit frame total, presented on a
//   valid/ready result port together with a sticky per-frame overflow flag.
//
// Ports
//   clk_i, rst_i          clock, async active-high reset
//   sum_i / sum_valid_i / sum_ready_o        sample stream in
//   len_i                 samples per frame (0 treated as 1), taken on the
//                         first accepted sample of a frame
//   result_o / result_valid_o / result_ready_i  frame total out
//   overflow_o            total wrapped past ACC_WIDTH bits this frame
//   busy_o                frame in progress (ACCUM or HOLD)
module sum_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     sum_i,
  input  logic                 sum_valid_i,
  output logic                 sum_ready_o,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic [ACC_WIDTH-1:0] result_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic                 overflow_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

  state_t               r_state, w_state_nxt;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_cnt, r_len;
  logic                 r_ovf;

  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_sum_ext;
  logic [ACC_WIDTH:0]   w_add;     // extra MSB is the carry out
  logic [LEN_WIDTH-1:0] w_cnt_inc;
  logic [LEN_WIDTH-1:0] w_len_eff;

  assign w_sum_ext = ACC_WIDTH'(sum_i);
  assign w_add     = {1'b0, r_acc} + {1'b0, w_sum_ext};
  assign w_cnt_inc = r_cnt + LEN_WIDTH'(1);
  // A zero length would never terminate; treat it as a one-sample frame.
  assign w_len_eff = (len_i == '0) ? LEN_WIDTH'(1) : len_i;
  assign w_accept  = sum_valid_i && sum_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    sum_ready_o    = 1'b1;
    result_valid_o = 1'b0;
    busy_o         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = (w_len_eff == LEN_WIDTH'(1)) ? S_HOLD : S_ACCUM;
      end
      S_ACCUM: begin
        busy_o = 1'b1;
        if (w_accept && (w_cnt_inc == r_len)) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        busy_o         = 1'b1;
        sum_ready_o    = 1'b0;
        result_valid_o = 1'b1;
        if (result_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath. Nothing is written in HOLD, so result and flag stay stable
  // until the downstream takes them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc <= w_sum_ext;
        r_cnt <= LEN_WIDTH'(1);
        r_len <= w_len_eff;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_add[ACC_WIDTH-1:0];
        r_cnt <= w_cnt_inc;
        r_ovf <= r_ovf | w_add[ACC_WIDTH];
      end
    end
  end

  assign result_o   = r_acc;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;
  localparam int W  = 32;
  localparam int AW = 33;
  localparam int LW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [W-1:0]  sum_i = '0;
  logic          sum_valid_i = 1'b0;
  logic          sum_ready_o;
  logic [LW-1:0] len_i = '0;
  logic [AW-1:0] result_o;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  logic          overflow_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  sum_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sum_i(sum_i), .sum_valid_i(sum_valid_i),
    .sum_ready_o(sum_ready_o), .len_i(len_i), .result_o(result_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .overflow_o(overflow_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // drives one sample for one edge; leaves sum_valid_i asserted
  task automatic push_sample(input logic [W-1:0] v, input logic [LW-1:0] l);
    sum_valid_i = 1'b1;
    sum_i       = v;
    len_i       = l;
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    checks++;
    if ({result_o, result_valid_o, overflow_o, busy_o, sum_ready_o} !== {{AW{1'b0}}, 4'b0001}) begin
      errors++;
      $display("FAIL reset_outputs: got res=%0h v=%0b ovf=%0b busy=%0b rdy=%0b want 0 0 0 0 1",
               result_o, result_valid_o, overflow_o, busy_o, sum_ready_o);
    end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    result_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) push_sample(W'(i), 8'd4);
    sum_valid_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b1 || result_o !== AW'(10) || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got v=%0b res=%0d ovf=%0b want 1 10 0", result_valid_o, result_o, overflow_o);
    end
    checks++;
    if (sum_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold_flags: got rdy=%0b busy=%0b want 0 1", sum_ready_o, busy_o);
    end
    step();
    checks++;
    if (result_valid_o !== 1'b0 || sum_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle: got v=%0b rdy=%0b busy=%0b want 0 1 0", result_valid_o, sum_ready_o, busy_o);
    end
  endtask

  task automatic test_len_one_zero();
    logic [LW-1:0] lens [2];
    lens[0] = 8'd1;
    lens[1] = 8'd0;
    result_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_sample(32'h1234, lens[k]);
      sum_valid_i = 1'b0;
      checks++;
      if (result_valid_o !== 1'b1 || result_o !== AW'(32'h1234)) begin
        errors++;
        $display("FAIL len_%0d_single: got v=%0b res=%0h want 1 1234", lens[k], result_valid_o, result_o);
      end
      step();
    end
  endtask

  task automatic test_hold();
    result_ready_i = 1'b0;
    push_sample(32'd5, 8'd3);
    sum_valid_i = 1'b0;
    step(); step();
    push_sample(32'd6, 8'd200);
    push_sample(32'd7, 8'd200);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (result_valid_o !== 1'b1 || result_o !== AW'(18) || sum_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable_%0d: got v=%0b res=%0d rdy=%0b want 1 18 0", i, result_valid_o, result_o, sum_ready_o);
      end
      sum_valid_i = 1'b1;
      sum_i = 32'd100;
      step();
    end
    sum_valid_i = 1'b0;
    result_ready_i = 1'b1;
    step();
    checks++;
    if (result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got v=%0b want 0", result_valid_o);
    end
    push_sample(32'd3, 8'd2);
    push_sample(32'd4, 8'd2);
    sum_valid_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b1 || result_o !== AW'(7)) begin
      errors++;
      $display("FAIL hold_next_frame: got v=%0b res=%0d want 1 7", result_valid_o, result_o);
    end
    step();
  endtask

  task automatic test_overflow();
    result_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) push_sample(32'hFFFF_FFFF, 8'd3);
    sum_valid_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b1 || result_o !== 33'h0_FFFF_FFFD || overflow_o !== 1'b1) begin
      errors++;
      $display("FAIL overflow_wrap: got v=%0b res=%0h ovf=%0b want 1 0fffffffd 1", result_valid_o, result_o, overflow_o);
    end
    step();
    for (int i = 0; i < 3; i++) push_sample(32'd1, 8'd3);
    sum_valid_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b1 || result_o !== AW'(3) || overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got v=%0b res=%0h ovf=%0b want 1 3 0", result_valid_o, result_o, overflow_o);
    end
    step();
  endtask

  task automatic test_mid_reset();
    result_ready_i = 1'b1;
    push_sample(32'd50, 8'd5);
    push_sample(32'd60, 8'd5);
    sum_valid_i = 1'b0;
    #3 rst_i = 1'b1;
    #1;
    checks++;
    if (result_o !== '0 || result_valid_o !== 1'b0 || busy_o !== 1'b0 || sum_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: got res=%0d v=%0b busy=%0b rdy=%0b want 0 0 0 1",
               result_o, result_valid_o, busy_o, sum_ready_o);
    end
    step(); step();
    rst_i = 1'b0;
    step();
    push_sample(32'd9, 8'd2);
    push_sample(32'd1, 8'd2);
    sum_valid_i = 1'b0;
    checks++;
    if (result_valid_o !== 1'b1 || result_o !== AW'(10)) begin
      errors++;
      $display("FAIL midreset_next_frame: got v=%0b res=%0d want 1 10", result_valid_o, result_o);
    end
    step();
  endtask

  // Reference: each frame's total is the plain integer sum of its samples;
  // the expected result is that sum modulo 2^AW, overflow is sum >= 2^AW.
  logic [W-1:0]  cur [$];
  logic [LW-1:0] flen;
  logic [AW-1:0] frame_res;
  logic          frame_ovf;
  logic [AW-1:0] exp_r [$];
  logic          exp_o [$];

  task automatic gen_frame(input int idx);
    int n, mode;
    longint unsigned tot;
    cur.delete();
    if (idx == 0)      flen = 8'd255;
    else if (idx == 1) flen = 8'd0;
    else if (idx == 2) flen = 8'd1;
    else               flen = LW'($urandom_range(1, 40));
    n = (flen == 0) ? 1 : int'(flen);
    mode = $urandom_range(0, 2);
    tot = 0;
    for (int i = 0; i < n; i++) begin
      logic [W-1:0] s;
      if (mode == 0)      s = $urandom;
      else if (mode == 1) s = W'($urandom_range(0, 255));
      else                s = 32'hFFFF_FFFF;
      cur.push_back(s);
      tot += longint'(s);
    end
    frame_res = AW'(tot);
    frame_ovf = (tot >> AW) != 0;
  endtask

  task automatic test_random();
    localparam int NF = 14;
    int fi, si, got, cycles;
    logic vld, acc, pop;
    fi = 0; si = 0; got = 0; cycles = 0;
    exp_r.delete(); exp_o.delete();
    gen_frame(0);
    while (got < NF && cycles < 20000) begin
      vld = (fi < NF) && ($urandom_range(0, 3) != 0);
      sum_valid_i = vld | ($urandom_range(0, 1) == 1 && result_valid_o);
      sum_i = vld ? cur[si] : W'($urandom);
      len_i = (vld && si == 0) ? flen : LW'($urandom);
      result_ready_i = ($urandom_range(0, 2) != 0);
      acc = vld && sum_ready_o;
      pop = result_valid_o && result_ready_i;
      step();
      cycles++;
      if (pop) begin
        void'(exp_r.pop_front());
        void'(exp_o.pop_front());
        got++;
      end
      if (acc) begin
        si++;
        if (si == cur.size()) begin
          exp_r.push_back(frame_res);
          exp_o.push_back(frame_ovf);
          checks++;
          if (result_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL rand_latency frame %0d: got v=%0b want 1", fi, result_valid_o);
          end
          fi++;
          si = 0;
          if (fi < NF) gen_frame(fi);
        end
      end
      if (result_valid_o) begin
        checks++;
        if (exp_r.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious: got result %0h with no frame pending", result_o);
        end else if (result_o !== exp_r[0] || overflow_o !== exp_o[0]) begin
          errors++;
          $display("FAIL rand_result frame %0d: got res=%0h ovf=%0b want res=%0h ovf=%0b",
                   got, result_o, overflow_o, exp_r[0], exp_o[0]);
        end
      end
    end
    sum_valid_i = 1'b0;
    checks++;
    if (got != NF || exp_r.size() != 0) begin
      errors++;
      $display("FAIL rand_count: got %0d results (%0d pending) want %0d", got, exp_r.size(), NF);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_one_zero();
    test_hold();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Sits directly downstream of the registered two-operand adder stage. It consumes the adder's WIDTH-bit sum stream and accumulates a programmable number of samples into one wider frame total.
- It presents the total on a valid/ready output with a per-frame overflow flag.
- Used to build running dot-product and checksum totals from the adder's per-cycle results.

Parameters:
- WIDTH, 32, width of incoming sum samples (matches the adder's WIDTH)
- ACC_WIDTH, 40, accumulator and result width; must be >= WIDTH
- LEN_WIDTH, 8, width of frame-length input and sample counter

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  asynchronous, active-high reset
- sum_i  input  WIDTH  sample from the adder stage, unsigned
- sum_valid_i  input  1  sum_i is valid this cycle
- sum_ready_o  output  1  block accepts a sample this cycle
- len_i  input  LEN_WIDTH  samples per frame, sampled on the first accepted sample of a frame
- result_o  output  ACC_WIDTH  frame total
- result_valid_o  output  1  result_o and overflow_o are valid
- result_ready_i  input  1  downstream accepts the result
- overflow_o  output  1  accumulation of the current or last frame wrapped past ACC_WIDTH bits
- busy_o  output  1  a frame is in progress (state ACCUM or HOLD)

Behaviour:
- Clock and reset: single clock clk_i; rst_i is asynchronous, active-high.
- Reset (asynchronous assert, synchronous-to-clock release):
  - state=IDLE; accumulator, counter and latched length = 0.
  - result_o=0, result_valid_o=0, overflow_o=0, busy_o=0, sum_ready_o=1 (combinational from state).
- Sample handshake: a sample is accepted when sum_valid_i && sum_ready_o at a rising edge. sum_ready_o=1 in IDLE and ACCUM, 0 in HOLD.
- Arithmetic:
  - sum_i is zero-extended to ACC_WIDTH, unsigned add.
  - The carry out of bit ACC_WIDTH-1 sets overflow (sticky for the frame); the accumulator wraps modulo 2^ACC_WIDTH.
- State IDLE:
  - On accept: acc <= zext(sum_i); cnt <= 1; len_q <= (len_i==0) ? 1 : len_i; overflow <= 0.
  - Next state is HOLD if the effective length == 1, else ACCUM.
  - No accept: stay in IDLE, registers hold.
- State ACCUM:
  - On accept: acc <= acc + zext(sum_i); cnt <= cnt+1; overflow |= carry.
  - If cnt+1 == len_q, go to HOLD; else stay.
  - Idle cycles (sum_valid_i=0) are allowed and hold all state.
  - len_i is ignored in ACCUM.
- State HOLD:
  - result_valid_o=1; result_o=acc and overflow_o are stable, and all outputs hold while result_ready_i=0.
  - When result_ready_i=1: go to IDLE next cycle; result_valid_o=0 from that cycle.
  - sum_valid_i is ignored in HOLD (not accepted).
- Latency: result_valid_o rises in the cycle after the edge that accepted the last sample of a frame.
- Throughput: at least one bubble per frame (the HOLD cycle); back-to-back frames of length L take at least L+1 cycles each.
- result_o outside HOLD: equals the live accumulator (not guaranteed meaningful); the bench checks it only while result_valid_o=1.
- overflow_o: reflects the current frame's sticky flag; cleared at the first accept of the next frame.
- busy_o=1 in ACCUM and HOLD.
- Length wrap: len_i = 2^LEN_WIDTH-1 is supported. cnt never exceeds len_q, so the counter does not wrap.
- Reset mid-frame: the partial frame is discarded, no result is emitted, and the block returns to IDLE.

Test Plan:
- Reset then len_i=4, samples 1,2,3,4 back-to-back with result_ready_i=1 -> result_valid_o=1 in the cycle after the 4th accept, result_o=10, overflow_o=0; 1 cycle later result_valid_o=0 and sum_ready_o=1.
- len_i=1 and len_i=0, single sample 0x1234 -> result_o=0x1234 one cycle later in both cases.
- len_i=3, samples 5,(gap 2 cycles),6,7, result_ready_i held 0 for 3 cycles -> result_o=18 held stable; sum_ready_o=0 throughout HOLD; sum_valid_i pulses during HOLD are not counted; the next frame starts cleanly at 0.
- ACC_WIDTH=33, WIDTH=32, len_i=3, samples 0xFFFFFFFF x3 -> result_o=0x0_FFFFFFFD (wrapped mod 2^33), overflow_o=1; next frame of samples 1,1,1 -> result_o=3, overflow_o=0.
- len_i=5, assert rst_i asynchronously (between edges) after 2 samples -> outputs zero immediately, busy_o=0; after release, a 2-sample frame with values 9,1 -> result_o=10.
- Random frames (len 1..255, random valid/ready gaps) against a scoreboard model -> every result and overflow flag matches, no result is lost or duplicated.
